// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: shares one data-memory port between instruction fetch and load/store, faulting bad accesses.
// Optional round-robin tie-breaking is enabled by defining MEM_ARB_ROUND_ROBIN_EN; otherwise data wins ties.
module mem_access_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned MEM_SIZE  = 8192
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_ack_o,
  output logic [31:0] if_rdata_o,
  output logic        if_err_o,
  input  logic        d_req_i,
  input  logic [2:0]  d_write_i,
  input  logic [2:0]  d_read_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_ack_o,
  output logic [31:0] d_rdata_o,
  output logic        d_err_o,
  output logic [31:0] mem_addr_o,
  output logic [2:0]  mem_write_o,
  output logic [2:0]  mem_read_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(MEM_SIZE) * 33'd4;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  state_e      state_q, state_d;
  logic        owner_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [2:0]  write_q, read_q;
  logic        err_q;
  logic        grant, sel_d, sel_err, noop, skip;
  logic        in_win, half, word, d_fault, if_fault;
  logic [31:0] sel_addr;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic        last_d_q;
`endif
  // pick the requester to latch: any pending one from IDLE, only the other one from RESP
  always_comb begin
    grant = 1'b0;
    sel_d = 1'b0;
    if (state_q == IDLE) begin
      grant = if_req_i | d_req_i;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      sel_d = d_req_i & (~if_req_i | ~last_d_q);
`else
      sel_d = d_req_i;
`endif
    end else if (state_q == RESP) begin
      grant = owner_q ? if_req_i : d_req_i;
      sel_d = ~owner_q;
    end
  end
  assign sel_addr = sel_d ? d_addr_i : if_addr_i;
  assign in_win   = sel_addr >= BASE_ADDR && {1'b0, sel_addr} < LIMIT;
  assign noop     = sel_d && d_write_i == 3'b000 && d_read_i == 3'b000;
  assign half     = d_write_i == 3'b010 || d_read_i == 3'b010 || d_read_i == 3'b100;
  assign word     = d_write_i == 3'b100 || d_read_i == 3'b101;
  assign d_fault  = !(d_write_i inside {3'b000, 3'b001, 3'b010, 3'b100}) || d_read_i > 3'b101 ||
                    (d_write_i != 3'b000 && d_read_i != 3'b000) || !in_win ||
                    (half && sel_addr[0]) || (word && sel_addr[1:0] != 2'b00);
  assign if_fault = !in_win || sel_addr[1:0] != 2'b00;
  assign sel_err  = sel_d ? (!noop && d_fault) : if_fault;
  assign skip     = sel_err | noop;
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  // faults and no-ops bypass the memory cycle and answer straight away
  always_comb begin
    state_d = grant ? (skip ? RESP : ACCESS) : (state_q == ACCESS ? RESP : IDLE);
  end
  // latch the granted request; read data is captured at the end of the access cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= 1'b0;
      addr_q  <= '0;
      write_q <= '0;
      read_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else if (grant) begin
      owner_q <= sel_d;
      addr_q  <= sel_addr;
      write_q <= sel_d ? d_write_i : 3'b000;
      read_q  <= sel_d ? d_read_i : 3'b101;
      wdata_q <= sel_d ? d_wdata_i : 32'h0;
      err_q   <= sel_err;
      rdata_q <= '0;
    end else if (state_q == ACCESS) begin
      rdata_q <= mem_rdata_i;
    end
  end
`ifdef MEM_ARB_ROUND_ROBIN_EN
  // winner of the last IDLE arbitration; starts as data so the first tie goes to fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_d_q <= 1'b1;
    else if (grant && state_q == IDLE) last_d_q <= sel_d;
  end
`endif
  // memory port is live only in ACCESS; responses only in RESP
  always_comb begin
    mem_addr_o  = state_q == ACCESS ? addr_q : 32'h0;
    mem_write_o = state_q == ACCESS ? write_q : 3'b000;
    mem_read_o  = state_q == ACCESS ? read_q : 3'b000;
    mem_wdata_o = state_q == ACCESS ? wdata_q : 32'h0;
    d_ack_o     = state_q == RESP && owner_q;
    if_ack_o    = state_q == RESP && !owner_q;
    d_err_o     = d_ack_o && err_q;
    if_err_o    = if_ack_o && err_q;
    d_rdata_o   = d_ack_o ? rdata_q : 32'h0;
    if_rdata_o  = if_ack_o ? rdata_q : 32'h0;
  end
endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb_mem_access_arbiter: randomized and directed checks of the arbiter against a byte-level memory model.
module tb_mem_access_arbiter;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int WORDS = 8192;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic if_req = 1'b0, d_req = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic [2:0] d_write = '0, d_read = '0;
  logic if_ack, if_err, d_ack, d_err;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [2:0] mem_write, mem_read;
  int checks = 0, errors = 0, wr_cnt = 0, act_cnt = 0;
  logic [31:0] mem [0:WORDS-1];
  logic [7:0] ref_mem [0:4*WORDS-1];
  logic [31:0] mw, msh;

  always #5 clk = ~clk;

  mem_access_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack), .if_rdata_o(if_rdata), .if_err_o(if_err),
    .d_req_i(d_req), .d_write_i(d_write), .d_read_i(d_read), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_ack_o(d_ack), .d_rdata_o(d_rdata), .d_err_o(d_err),
    .mem_addr_o(mem_addr), .mem_write_o(mem_write), .mem_read_o(mem_read), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  // data memory as the core sees it: combinational extended read, byte-lane write on the clock
  always_comb begin
    mw = mem[mem_addr[14:2]];
    msh = mw >> {mem_addr[1:0], 3'b000};
    case (mem_read)
      3'b001: mem_rdata = {24'h0, msh[7:0]};
      3'b010: mem_rdata = {16'h0, msh[15:0]};
      3'b011: mem_rdata = {{24{msh[7]}}, msh[7:0]};
      3'b100: mem_rdata = {{16{msh[15]}}, msh[15:0]};
      3'b101: mem_rdata = mw;
      default: mem_rdata = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (mem_write != 3'b000) wr_cnt <= wr_cnt + 1;
    if (mem_write != 3'b000 || mem_read != 3'b000) act_cnt <= act_cnt + 1;
    case (mem_write)
      3'b001: mem[mem_addr[14:2]][{mem_addr[1:0], 3'b000} +: 8] <= mem_wdata[7:0];
      3'b010: mem[mem_addr[14:2]][{mem_addr[1], 4'b0000} +: 16] <= mem_wdata[15:0];
      3'b100: mem[mem_addr[14:2]] <= mem_wdata;
      default: ;
    endcase
  end

  function automatic bit in_win(logic [31:0] a);
    return a >= BASE && (a - BASE) < 32'(4 * WORDS);
  endfunction

  function automatic int op_size(logic [2:0] w, logic [2:0] r);
    if (w == 3'b001 || r == 3'b001 || r == 3'b011) return 1;
    if (w == 3'b010 || r == 3'b010 || r == 3'b100) return 2;
    return 4;
  endfunction

  function automatic bit ref_fault(bit f, logic [2:0] w, logic [2:0] r, logic [31:0] a);
    if (f) return !in_win(a) || (a % 32'd4) != 0;
    if (w == 3'b000 && r == 3'b000) return 1'b0;
    if (w != 3'b000 && r != 3'b000) return 1'b1;
    if (!(w inside {3'b000, 3'b001, 3'b010, 3'b100}) || r > 3'b101) return 1'b1;
    return !in_win(a) || (a % 32'(op_size(w, r))) != 0;
  endfunction

  function automatic logic [31:0] ref_load(logic [2:0] r, logic [31:0] a);
    int n;
    longint v;
    n = op_size(3'b000, r);
    v = 0;
    for (int i = 0; i < n; i++) v = v | (longint'(ref_mem[a - BASE + 32'(i)]) << (8 * i));
    if ((r == 3'b011 || r == 3'b100) && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [2:0] w, input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i < op_size(w, 3'b000); i++) ref_mem[a - BASE + 32'(i)] = 8'(d >> (8 * i));
  endtask

  task automatic run_d(input logic [2:0] w, input logic [2:0] r, input logic [31:0] a, input logic [31:0] wd,
                       output bit got, output int lat, output logic e, output logic [31:0] rd,
                       output int wrs, output int acts);
    int wr0, act0;
    wr0 = wr_cnt;
    act0 = act_cnt;
    d_write = w; d_read = r; d_addr = a; d_wdata = wd; d_req = 1'b1;
    got = 1'b0; lat = 0; e = 1'b0; rd = '0;
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      if (d_ack === 1'b1) begin got = 1'b1; e = d_err; rd = d_rdata; end
    end
    d_req = 1'b0;
    @(negedge clk);
    wrs = wr_cnt - wr0;
    acts = act_cnt - act0;
  endtask

  task automatic run_if(input logic [31:0] a, output bit got, output int lat, output logic e,
                        output logic [31:0] rd, output int wrs, output int acts);
    int wr0, act0;
    wr0 = wr_cnt;
    act0 = act_cnt;
    if_addr = a; if_req = 1'b1;
    got = 1'b0; lat = 0; e = 1'b0; rd = '0;
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      if (if_ack === 1'b1) begin got = 1'b1; e = if_err; rd = if_rdata; end
    end
    if_req = 1'b0;
    @(negedge clk);
    wrs = wr_cnt - wr0;
    acts = act_cnt - act0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; d_req = 1'b0; if_req = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({if_ack, if_err, d_ack, d_err} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000", {if_ack, if_err, d_ack, d_err}); end
    checks++; if ({if_rdata, d_rdata} !== 64'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", {if_rdata, d_rdata}); end
    checks++; if ({mem_write, mem_read} !== 6'h0) begin errors++; $display("FAIL reset_mem_ctrl: got %b want 000000", {mem_write, mem_read}); end
    checks++; if ({mem_addr, mem_wdata} !== 64'h0) begin errors++; $display("FAIL reset_mem_bus: got %h want 0", {mem_addr, mem_wdata}); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({if_ack, d_ack, mem_write, mem_read} !== 8'h0) begin errors++; $display("FAIL reset_release_idle: got %b want 0", {if_ack, d_ack, mem_write, mem_read}); end
  endtask

  task automatic test_lw_directed;
    bit got; int lat, wrs, acts; logic e; logic [31:0] rd, a;
    a = 32'h8000_0010;
    run_d(3'b100, 3'b000, a, 32'hDEAD_BEEF, got, lat, e, rd, wrs, acts);
    checks++; if (got !== 1'b1 || e !== 1'b0 || wrs != 1) begin errors++; $display("FAIL lw_setup_store: got ack=%0b err=%0b writes=%0d want 1 0 1", got, e, wrs); end
    ref_store(3'b100, a, 32'hDEAD_BEEF);
    d_write = 3'b000; d_read = 3'b101; d_addr = a; d_req = 1'b1;
    @(negedge clk);
    checks++; if (mem_read !== 3'b101) begin errors++; $display("FAIL lw_mem_read_cyc1: got %b want 101", mem_read); end
    checks++; if (mem_addr !== a) begin errors++; $display("FAIL lw_mem_addr_cyc1: got %h want %h", mem_addr, a); end
    checks++; if (d_ack !== 1'b0) begin errors++; $display("FAIL lw_early_ack: got %b want 0", d_ack); end
    @(negedge clk);
    checks++; if (d_ack !== 1'b1) begin errors++; $display("FAIL lw_ack_cyc2: got %b want 1", d_ack); end
    checks++; if (d_rdata !== ref_load(3'b101, a)) begin errors++; $display("FAIL lw_rdata: got %h want %h", d_rdata, ref_load(3'b101, a)); end
    d_req = 1'b0;
    @(negedge clk);
    checks++; if ({d_ack, d_err, d_rdata, mem_read} !== 37'h0) begin errors++; $display("FAIL lw_after_resp: got ack=%b rdata=%h want 0", d_ack, d_rdata); end
  endtask

  task automatic test_byte;
    bit got; int lat, wrs, acts; logic e; logic [31:0] rd, a;
    a = 32'h8000_0020;
    run_d(3'b001, 3'b000, a, 32'h1234_56AB, got, lat, e, rd, wrs, acts);
    checks++; if (got !== 1'b1 || e !== 1'b0 || wrs != 1) begin errors++; $display("FAIL sb_store: got ack=%0b err=%0b writes=%0d want 1 0 1", got, e, wrs); end
    ref_store(3'b001, a, 32'h1234_56AB);
    run_d(3'b000, 3'b001, a, 32'h0, got, lat, e, rd, wrs, acts);
    checks++; if (rd !== 32'h0000_00AB) begin errors++; $display("FAIL lbu_value: got %h want 000000ab", rd); end
    run_d(3'b000, 3'b011, a, 32'h0, got, lat, e, rd, wrs, acts);
    checks++; if (rd !== 32'hFFFF_FFAB) begin errors++; $display("FAIL lb_value: got %h want ffffffab", rd); end
    run_d(3'b000, 3'b100, a, 32'h0, got, lat, e, rd, wrs, acts);
    checks++; if (rd !== ref_load(3'b100, a)) begin errors++; $display("FAIL lh_value: got %h want %h", rd, ref_load(3'b100, a)); end
  endtask

  task automatic test_fault;
    bit got; int lat, wrs, acts; logic e; logic [31:0] rd;
    run_d(3'b100, 3'b000, 32'h8000_0002, 32'h5555_5555, got, lat, e, rd, wrs, acts);
    checks++; if (got !== 1'b1 || e !== 1'b1) begin errors++; $display("FAIL sw_misaligned_err: got ack=%0b err=%0b want 1 1", got, e); end
    checks++; if (lat != 1) begin errors++; $display("FAIL sw_misaligned_latency: got %0d want 1", lat); end
    checks++; if (wrs != 0 || acts != 0) begin errors++; $display("FAIL sw_misaligned_mem: got writes=%0d ops=%0d want 0 0", wrs, acts); end
    run_if(32'h8000_8000, got, lat, e, rd, wrs, acts);
    checks++; if (got !== 1'b1 || e !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL fetch_oor_err: got ack=%0b err=%0b rdata=%h want 1 1 0", got, e, rd); end
    checks++; if (acts != 0) begin errors++; $display("FAIL fetch_oor_mem: got ops=%0d want 0", acts); end
    run_d(3'b100, 3'b101, 32'h8000_0010, 32'h1, got, lat, e, rd, wrs, acts);
    checks++; if (got !== 1'b1 || e !== 1'b1 || acts != 0) begin errors++; $display("FAIL both_codes: got ack=%0b err=%0b ops=%0d want 1 1 0", got, e, acts); end
    run_d(3'b011, 3'b000, 32'h8000_0010, 32'h1, got, lat, e, rd, wrs, acts);
    checks++; if (e !== 1'b1 || acts != 0) begin errors++; $display("FAIL undefined_write: got err=%0b ops=%0d want 1 0", e, acts); end
    run_d(3'b000, 3'b000, 32'h8000_0013, 32'h1, got, lat, e, rd, wrs, acts);
    checks++; if (got !== 1'b1 || e !== 1'b0 || rd !== 32'h0 || acts != 0) begin errors++; $display("FAIL noop: got ack=%0b err=%0b rdata=%h ops=%0d want 1 0 0 0", got, e, rd, acts); end
  endtask

  task automatic test_reset_mid_access;
    bit got; int lat, wrs, acts, wr0; logic e; logic [31:0] rd, a, old;
    a = 32'h8000_0040;
    old = ref_load(3'b101, a);
    wr0 = wr_cnt;
    d_write = 3'b100; d_read = 3'b000; d_addr = a; d_wdata = ~old; d_req = 1'b1;
    @(negedge clk);
    checks++; if (mem_write !== 3'b100) begin errors++; $display("FAIL rst_mid_in_access: got %b want 100", mem_write); end
    rst_n = 1'b0;
    #1;
    checks++; if (mem_write !== 3'b000) begin errors++; $display("FAIL rst_mid_write_drop: got %b want 000", mem_write); end
    d_req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++; if ({if_ack, d_ack} !== 2'b00) begin errors++; $display("FAIL rst_mid_acks: got %b want 00", {if_ack, d_ack}); end
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (wr_cnt != wr0) begin errors++; $display("FAIL rst_mid_no_write: got %0d writes want 0", wr_cnt - wr0); end
    run_d(3'b000, 3'b101, a, 32'h0, got, lat, e, rd, wrs, acts);
    checks++; if (rd !== old) begin errors++; $display("FAIL rst_mid_word_kept: got %h want %h", rd, old); end
  endtask

  task automatic test_tie;
    bit last_d, d_first; int dc, ic; logic [31:0] drd, ird, da, ia;
    rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    last_d = 1'b1;
    for (int k = 0; k < 3; k++) begin
      d_first = RR ? !last_d : 1'b1;
      last_d = d_first;
      da = BASE + 32'($urandom_range(0, 63) * 4);
      ia = BASE + 32'($urandom_range(0, 63) * 4);
      d_write = 3'b000; d_read = 3'b101; d_addr = da; if_addr = ia; d_req = 1'b1; if_req = 1'b1;
      dc = 0; ic = 0; drd = 'x; ird = 'x;
      for (int c = 1; c <= 8; c++) begin
        @(negedge clk);
        if (d_ack === 1'b1 && dc == 0) begin dc = c; drd = d_rdata; d_req = 1'b0; end
        if (if_ack === 1'b1 && ic == 0) begin ic = c; ird = if_rdata; if_req = 1'b0; end
      end
      d_req = 1'b0; if_req = 1'b0;
      checks++; if (dc != (d_first ? 2 : 4)) begin errors++; $display("FAIL tie%0d_d_ack_cycle: got %0d want %0d", k, dc, d_first ? 2 : 4); end
      checks++; if (ic != (d_first ? 4 : 2)) begin errors++; $display("FAIL tie%0d_if_ack_cycle: got %0d want %0d", k, ic, d_first ? 4 : 2); end
      checks++; if (drd !== ref_load(3'b101, da)) begin errors++; $display("FAIL tie%0d_d_rdata: got %h want %h", k, drd, ref_load(3'b101, da)); end
      checks++; if (ird !== ref_load(3'b101, ia)) begin errors++; $display("FAIL tie%0d_if_rdata: got %h want %h", k, ird, ref_load(3'b101, ia)); end
    end
  endtask

  task automatic test_back_to_back;
    int dc, ic; logic [31:0] da, ia, ird;
    da = BASE + 32'h100;
    ia = BASE + 32'h104;
    d_write = 3'b000; d_read = 3'b101; d_addr = da; d_req = 1'b1;
    dc = 0; ic = 0; ird = 'x;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (d_ack === 1'b1 && dc == 0) begin dc = c; d_req = 1'b0; end
      if (if_ack === 1'b1 && ic == 0) begin ic = c; ird = if_rdata; if_req = 1'b0; end
      if (c == 1) begin if_addr = ia; if_req = 1'b1; end
    end
    d_req = 1'b0; if_req = 1'b0;
    checks++; if (dc != 2) begin errors++; $display("FAIL b2b_d_ack_cycle: got %0d want 2", dc); end
    checks++; if (ic != 4) begin errors++; $display("FAIL b2b_if_ack_cycle: got %0d want 4", ic); end
    checks++; if (ird !== ref_load(3'b101, ia)) begin errors++; $display("FAIL b2b_if_rdata: got %h want %h", ird, ref_load(3'b101, ia)); end
  endtask

  task automatic test_random;
    bit got, f, noop, exp_e; int lat, wrs, acts, k; logic e; logic [31:0] rd, a, wd, exp_rd; logic [2:0] w, r;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0: a = BASE - 32'($urandom_range(1, 4));
        1: a = BASE + 32'h7FFC + 32'($urandom_range(0, 7));
        default: a = BASE + 32'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      f = $urandom_range(0, 3) == 0;
      k = $urandom_range(0, 11);
      w = 3'b000; r = 3'b000;
      if (k <= 2) w = 3'(1 << k);
      else if (k <= 7) r = 3'(k - 2);
      else if (k == 9) begin w = 3'($urandom); r = 3'($urandom); end
      wd = $urandom;
      noop = !f && w == 3'b000 && r == 3'b000;
      exp_e = ref_fault(f, w, r, a);
      exp_rd = exp_e ? 32'h0 : f ? ref_load(3'b101, a) : (r != 3'b000 ? ref_load(r, a) : 32'h0);
      if (f) run_if(a, got, lat, e, rd, wrs, acts);
      else run_d(w, r, a, wd, got, lat, e, rd, wrs, acts);
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL rnd%0d_ack: no ack within 10 cycles (fetch=%0b a=%h)", n, f, a); end
      checks++; if (e !== exp_e) begin errors++; $display("FAIL rnd%0d_err: got %0b want %0b (fetch=%0b w=%b r=%b a=%h)", n, e, exp_e, f, w, r, a); end
      checks++; if (rd !== exp_rd) begin errors++; $display("FAIL rnd%0d_rdata: got %h want %h (fetch=%0b r=%b a=%h)", n, rd, exp_rd, f, r, a); end
      if (!noop) begin
        checks++; if (lat != (exp_e ? 1 : 2)) begin errors++; $display("FAIL rnd%0d_latency: got %0d want %0d", n, lat, exp_e ? 1 : 2); end
      end
      checks++; if (acts != ((exp_e || noop) ? 0 : 1)) begin errors++; $display("FAIL rnd%0d_mem_ops: got %0d want %0d", n, acts, (exp_e || noop) ? 0 : 1); end
      checks++; if (wrs != ((!f && !exp_e && w != 3'b000) ? 1 : 0)) begin errors++; $display("FAIL rnd%0d_writes: got %0d want %0d", n, wrs, (!f && !exp_e && w != 3'b000) ? 1 : 0); end
      if (!f && !exp_e && w != 3'b000) ref_store(w, a, wd);
    end
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      mem[i] = $urandom;
      for (int b = 0; b < 4; b++) ref_mem[4 * i + b] = 8'(mem[i] >> (8 * b));
    end
    @(negedge clk);
    test_reset;
    test_lw_directed;
    test_byte;
    test_fault;
    test_back_to_back;
    test_random;
    test_reset_mid_access;
    test_tie;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
